serial_bit_source: RTL
======================

# serial_bit_source

- Upstream stage for the single-bit Moore sequence detector.
- Accepts a parallel word through a load/ready handshake and drives it out one bit at a time on `j`, each bit held a programmable number of clocks.
- `j` is a registered, glitch-free stream that the detector samples on the same `clk`.
- `busy`/`done` let a controller or bench pace words without counting cycles.

## Interface

Parameters:
- `WIDTH`, 8: bits per word; must be ≥ 2.
- `HOLD`, 1: clocks each bit is held on `j`; must be ≥ 1.
- `MSB_FIRST`, 1: 1 = shift out `din[WIDTH-1]` first; 0 = `din[0]` first.

Ports:
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: reset, synchronous and active-low.
- `din` input WIDTH: word to serialize; sampled only on an accepted load.
- `load` input 1: request to start a word.
- `ready` output 1: combinational; a load is accepted on a rising edge where `load && ready`.
- `j` output 1: registered serial bit to the detector.
- `busy` output 1: registered; high while a word is being shifted.
- `done` output 1: registered; one-cycle pulse after a word's last bit period ends.

## Operation

- Internal state:
  - FSM with states IDLE and SHIFT.
  - Shift register `sh` of WIDTH bits.
  - Bit counter `bcnt`, 0..WIDTH-1.
  - Hold counter `hcnt`, 0..HOLD-1, sized `$clog2(HOLD)+1`.
- Reset (`rst==0` at a rising edge):
  - State IDLE; `j=0`, `busy=0`, `done=0`; `sh`, `bcnt`, `hcnt` all cleared.
  - Takes priority over every other event.
- `ready` = (state==IDLE) OR (state==SHIFT AND `bcnt==WIDTH-1` AND `hcnt==HOLD-1`).
- IDLE:
  - `j=0`.
  - On `load` (ready is 1): capture `din` into `sh`, go to SHIFT, set `j` to the first bit, `bcnt=0`, `hcnt=0`, `busy=1`.
- SHIFT, per edge:
  - If `hcnt<HOLD-1`: `hcnt++`, `j` unchanged.
  - Else if `bcnt<WIDTH-1`: `hcnt=0`, `bcnt++`, shift `sh` toward the output end, `j` = next bit.
  - Else (last bit, last hold cycle) there are two cases:
    - `load` high: back-to-back. Capture the new `din`, `j` = its first bit, counters cleared, stay in SHIFT, `busy` stays 1.
    - `load` low: go to IDLE, `j=0`, `busy=0`.
    - In both cases `done=1` for the next cycle.
- `done` is high only in the cycle following word completion, otherwise 0.
- `load` while `ready==0` is ignored with no side effect. `din` is not re-sampled mid-word.
- Bit order is fixed by `MSB_FIRST`. The shift direction is chosen at elaboration; no runtime muxing.

## Timing

- Load-to-first-bit latency: 1 clock. An accept at edge E0 gives the first bit on `j` after E0.
- Bit k (0-based) occupies cycles E0+k·HOLD+1 through E0+(k+1)·HOLD.
- Word duration: exactly WIDTH·HOLD cycles with `busy=1`.
- `done` is high for the single cycle after edge E0+WIDTH·HOLD. On a back-to-back load, that cycle also carries the first bit of the next word.
- Back-to-back words produce a continuous stream with zero idle cycles between them.
- Idle gap: if `load` is low at completion, `j=0` from the next cycle until the cycle after a new accept.
- Reset mid-word: the next cycle has `j=0`, `busy=0`, `done=0`, `ready=1`. The partial word is discarded and no `done` is issued for it.
- Reset asserted in the same edge as a `load`: reset wins and the load is not accepted.

## Test plan

- **Reset:** hold `rst=0` for 2 clocks with `load=1`, `din=8'hFF` → `j=0`, `busy=0`, `done=0`, `ready=1`; no word is started after `rst` rises until `load` is sampled again.
- **Single word** (WIDTH=8, HOLD=1, MSB_FIRST=1): `din=8'b1011_0010`, pulse `load` one cycle → `j` = 1,0,1,1,0,0,1,0 on cycles 1–8 after the accept. `busy` is high on cycles 1–8. `done` is high on cycle 9 only. `j=0` from cycle 9.
- **Back-to-back:** `din=8'hA5` then `8'h3C`, with `load` held high across the ready cycle → 16 contiguous bits 1010_0101_0011_1100 with no gap. `done` pulses on cycle 9 (during the first bit of `8'h3C`) and on cycle 17.
- **Hold and bit order** (HOLD=4, MSB_FIRST=0): `din=8'b0000_0110` → `j` is 0 for 4 cycles, 1 for 8 cycles, then 0 for 20 cycles. `busy` is high for 32 cycles; `done` is high on cycle 33.
- **Ignored load:** during word `8'h0F`, assert `load` with `din=8'hFF` at bit 3 → the stream remains 0,0,0,0,1,1,1,1 and only one `done` is issued.
- **Reset mid-word:** assert `rst=0` during bit 3 of `8'hFF` → on the next cycle `j=0`, `busy=0`, `ready=1`, and `done` never asserts for that word.

Source files
------------

// File: rtl/serial_bit_source.sv
// serial_bit_source
// Parallel-to-serial feeder for the single-bit sequence detector. A word is
// accepted through a load/ready handshake and driven out one bit at a time on
// j, each bit held for HOLD clocks. j, busy and done are all registered so the
// detector sees a clean stream on the same clock.
//
// Handshake: ready is combinational and depends only on internal state (never
// on load). A word is accepted on a rising edge where load && ready are both
// high; load while ready is low is ignored with no side effect, and din is
// sampled only at that accepting edge.
//
// The FSM state is held in state_q (S_IDLE / S_SHIFT); checkers can bind to it
// directly by hierarchical reference.

module serial_bit_source #(
  parameter int WIDTH     = 8,    // bits per word, at least 2
  parameter int HOLD      = 1,    // clocks each bit stays on j, at least 1
  parameter bit MSB_FIRST = 1'b1  // 1: din[WIDTH-1] leaves first, 0: din[0] first
) (
  input  logic             clk,
  input  logic             rst,    // synchronous, active low
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             j,
  output logic             busy,
  output logic             done
);

  // Counter widths: bcnt spans 0..WIDTH-1, hcnt spans 0..HOLD-1.
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HW = $clog2(HOLD) + 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic             j_q, j_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             hold_last;
  logic             word_last;
  logic             accept;

  // The bit that sits at the output end of a word. The direction is fixed at
  // elaboration, so this reduces to a plain wire selection.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Move the shift register one place toward its output end, filling with 0.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  // Handshake: idle always accepts; while shifting, only the final hold cycle
  // of the final bit accepts, which is what makes back-to-back words gapless.
  always_comb begin
    hold_last = (hcnt_q == HOLD_LAST);
    word_last = hold_last && (bcnt_q == BIT_LAST);
    ready     = (state_q == S_IDLE) || ((state_q == S_SHIFT) && word_last);
    accept    = load && ready;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcnt_d  = bcnt_q;
    hcnt_d  = hcnt_q;
    j_d     = j_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        j_d    = 1'b0;
        busy_d = 1'b0;
        if (accept) begin
          state_d = S_SHIFT;
          sh_d    = din;
          j_d     = lead_bit(din);
          bcnt_d  = '0;
          hcnt_d  = '0;
          busy_d  = 1'b1;
        end
      end

      S_SHIFT: begin
        if (!hold_last) begin
          // Still holding the current bit.
          hcnt_d = hcnt_q + HW'(1);
        end else if (!word_last) begin
          // Hold expired, more bits remain: present the next one.
          hcnt_d = '0;
          bcnt_d = bcnt_q + BW'(1);
          sh_d   = advance(sh_q);
          j_d    = lead_bit(advance(sh_q));
        end else begin
          // Last hold cycle of the last bit: the word completes here.
          done_d = 1'b1;
          hcnt_d = '0;
          bcnt_d = '0;
          if (accept) begin
            // Back-to-back word: first bit follows with no idle cycle.
            sh_d   = din;
            j_d    = lead_bit(din);
            busy_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            sh_d    = '0;
            j_d     = 1'b0;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        sh_d    = '0;
        bcnt_d  = '0;
        hcnt_d  = '0;
        j_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset wins over any load presented on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bcnt_q  <= '0;
      hcnt_q  <= '0;
      j_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      hcnt_q  <= hcnt_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Registered outputs straight from their flops.
  always_comb begin
    j    = j_q;
    busy = busy_q;
    done = done_q;
  end

endmodule
